dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, read-allocate data cache for the memory stage of the pipelined Y86-64 core.
- Sits between the M-stage memory request and a word-wide backing-memory port with a variable-latency req/ack handshake.
- Drives h_memory_access_o, which the pipeline controller uses to freeze F/D/E/M and bubble W while a miss fill or write-through is outstanding.

Parameters:
IDX_W, 4, index bits; cache holds 2^IDX_W lines
LINE_WORDS, 4, 64-bit words per line (fixed at 4; offset bits [4:3])

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
M_read_i  in  1  M-stage load (mrmovq/popq/ret)
M_write_i  in  1  M-stage store (rmmovq/pushq/call)
M_addr_i  in  64  byte address
M_data_i  in  64  store data
m_data_o  out  64  load data
m_error_o  out  1  access error, maps to SADR upstream
h_memory_access_o  out  1  stall request to pipeline control
mem_req_o  out  1  backing-memory request
mem_we_o  out  1  1 = write, 0 = read
mem_addr_o  out  64  8-byte-aligned word address
mem_wdata_o  out  64  write data
mem_rdata_i  in  64  read data, valid with mem_ack_i
mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_i=1):
  - All valid bits clear; FSM to IDLE; fill counter 0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - h_memory_access_o=0, m_error_o=0, m_data_o=0.
- Address split: offset=addr[4:3]; index=addr[5+IDX_W-1:5]; tag=addr[63:5+IDX_W]. Storage is regs (tag, valid, 4x64 data per line).
- hit = valid[index] & (tag match), combinational.
- Error (combinational):
  - Condition: (M_read_i|M_write_i) & addr[2:0]!=0, or M_read_i&M_write_i.
  - Response: m_error_o=1, no stall, no memory traffic, no cache update.
- FSM states: IDLE, FILL, WRITE.
- IDLE:
  - Read hit: m_data_o = line word at offset, same cycle; stall=0.
  - Read miss: stall=1; next state FILL with cnt=0.
  - Write, any hit status: stall=1; next state WRITE.
  - No request: m_data_o=0, stall=0.
- FILL:
  - Outputs: stall=1; mem_req_o=1, mem_we_o=0, mem_addr_o={tag,index,cnt,3'b000}.
  - On req&ack: store mem_rdata_i into word cnt, cnt++.
  - On ack with cnt=3: write tag, set valid, go IDLE. The following IDLE cycle hits and releases the stall.
  - Valid is never set on a partial line.
- WRITE:
  - Outputs: mem_req_o=1, mem_we_o=1, mem_addr_o=M_addr_i, mem_wdata_o=M_data_i; stall=~mem_ack_i.
  - On ack: if hit, update the cached word at offset (write-through, no write-allocate); go IDLE. The pipeline advances on that same edge.
- Handshake rules:
  - mem_addr_o, mem_wdata_o and mem_we_o are stable while mem_req_o=1 and ack is not yet seen.
  - Ack may arrive in the first req cycle.
  - mem_req_o deasserts the cycle after the final ack.
  - mem_ack_i with mem_req_o=0 is ignored.
- M inputs are held stable by the stall. The block does not re-sample them mid-FSM except for the address and data presented in WRITE.
- Reset mid-FILL or mid-WRITE:
  - Partial line is discarded; valid stays 0; req drops immediately.
  - Pending write is abandoned.
- Latency:
  - Read hit: 0 stall cycles.
  - Read miss: 1 + sum of 4 ack latencies.
  - Write: 1 + ack latency, minus 1 when ack is combinational.

Test Plan:
- Cold read 0x100, ack 2 cycles after each req:
  - mem reads 0x100, 0x108, 0x110, 0x118.
  - Stall held for 13 cycles, then load returns word0.
  - Read 0x108 next cycle hits with 0 stall and no mem_req.
- Store 0xDEAD to 0x110 after fill, immediate ack:
  - One mem write at 0x110; stall 1 cycle.
  - Subsequent load 0x110 hits and returns 0xDEAD.
- Store to uncached 0x4000:
  - Mem write issued; line not allocated.
  - Load 0x4000 then misses and performs a 4-word fill.
- Load 0x103:
  - m_error_o=1, h_memory_access_o=0, mem_req_o never asserts.
  - Same result for M_read_i=M_write_i=1.
- Conflict: fill 0x100, then read 0x100+(32<<IDX_W):
  - Miss and refill evicts the line.
  - Re-read 0x100 misses again.
- Assert rst_i after 2 of 4 fill acks:
  - mem_req_o=0 immediately, all valid clear.
  - Re-read of the same address misses and performs a full 4-word fill.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// Backing-memory port of the data cache: word-wide req/ack handshake.
interface dcache_ctrl_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [63:0] mem_rdata_i;
  logic        mem_ack_i;

  // Cache side drives the request, memory side answers.
  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, read-allocate data cache for the M stage.
// Misses fill a 4-word line from backing memory; stores always go through
// to memory and update the cached copy only when the line is present.
module dcache_ctrl #(
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          M_read_i,
  input  logic          M_write_i,
  input  logic [63:0]   M_addr_i,
  input  logic [63:0]   M_data_i,
  output logic [63:0]   m_data_o,
  output logic          m_error_o,
  output logic          h_memory_access_o,
  dcache_ctrl_if.master mem
);

  localparam int unsigned NLINES = 1 << IDX_W;
  localparam int unsigned TAG_W  = 64 - 5 - IDX_W;
  localparam logic [1:0]  LAST   = 2'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [63:0]         addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [NLINES-1:0]   valid_q, valid_d;

  logic [TAG_W-1:0]    tag_q  [NLINES];
  logic [63:0]         data_q [NLINES][LINE_WORDS];

  logic [1:0]          offset;
  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic                hit, err, ack;
  logic                fill_we, hit_we, tag_we;

  assign offset = M_addr_i[4:3];
  assign idx    = M_addr_i[5 +: IDX_W];
  assign tag    = M_addr_i[63 -: TAG_W];
  assign hit    = valid_q[idx] & (tag_q[idx] == tag);
  assign err    = ((M_read_i | M_write_i) & (|M_addr_i[2:0])) | (M_read_i & M_write_i);
  // An ack with no request outstanding is ignored.
  assign ack    = mem.mem_ack_i & req_q;

  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;

  // Next-state logic: registered memory-port outputs are loaded on state entry
  // so they stay stable until the ack that completes each word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = valid_q;
    fill_we = 1'b0;
    hit_we  = 1'b0;
    tag_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!err && M_write_i) begin
          state_d = WRITE;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = M_addr_i;
          wdata_d = M_data_i;
        end else if (!err && M_read_i && !hit) begin
          state_d = FILL;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = {M_addr_i[63:5], 2'b00, 3'b000};
        end
      end
      FILL: begin
        if (ack) begin
          fill_we = 1'b1;
          if (cnt_q == LAST) begin
            tag_we       = 1'b1;
            valid_d[idx] = 1'b1;
            state_d      = IDLE;
            cnt_d        = '0;
            req_d        = 1'b0;
            addr_d       = '0;
          end else begin
            cnt_d  = cnt_q + 2'd1;
            addr_d = {M_addr_i[63:5], cnt_q + 2'd1, 3'b000};
          end
        end
      end
      WRITE: begin
        if (ack) begin
          hit_we  = hit;
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; reset drops the request at once and discards any partial line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (fill_we) data_q[idx][cnt_q]  <= mem.mem_rdata_i;
    if (hit_we)  data_q[idx][offset] <= wdata_q;
    if (tag_we)  tag_q[idx]          <= tag;
  end

  // Load data and stall request toward the pipeline.
  always_comb begin
    m_error_o         = err;
    m_data_o          = '0;
    h_memory_access_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (M_read_i && !err && hit) m_data_o = data_q[idx][offset];
        h_memory_access_o = !err && (M_write_i || (M_read_i && !hit));
      end
      FILL:    h_memory_access_o = 1'b1;
      WRITE:   h_memory_access_o = !ack;
      default: h_memory_access_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a variable-latency backing memory.
module tb_dcache_ctrl;

  logic        clk;
  logic        rst;
  logic        M_read, M_write;
  logic [63:0] M_addr, M_data;
  logic [63:0] m_data;
  logic        m_error, h_mem;

  dcache_ctrl_if mif ();

  dcache_ctrl #(.IDX_W(4), .LINE_WORDS(4)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .M_read_i          (M_read),
    .M_write_i         (M_write),
    .M_addr_i          (M_addr),
    .M_data_i          (M_data),
    .m_data_o          (m_data),
    .m_error_o         (m_error),
    .h_memory_access_o (h_mem),
    .mem               (mif)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          ack_lat = 0;
  int          wait_cnt = 0;
  logic [63:0] mem_arr [logic [63:0]];
  logic [63:0] rd_log [$];
  logic [63:0] wr_log [$];
  logic [63:0] wr_data_last = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return {a[31:0] ^ 32'hCAFE_0000, a[31:0]};
  endfunction

  // Backing memory: acks ack_lat cycles after the request (or its previous ack).
  initial begin
    mif.mem_ack_i   = 1'b0;
    mif.mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (mif.mem_req_o === 1'b1) begin
        if (wait_cnt == ack_lat) begin
          mif.mem_ack_i = 1'b1;
          wait_cnt = 0;
          if (mif.mem_we_o === 1'b1) begin
            mem_arr[mif.mem_addr_o] = mif.mem_wdata_o;
            wr_log.push_back(mif.mem_addr_o);
            wr_data_last = mif.mem_wdata_o;
          end else begin
            mif.mem_rdata_i = mem_rd(mif.mem_addr_o);
            rd_log.push_back(mif.mem_addr_o);
          end
        end else begin
          mif.mem_ack_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        mif.mem_ack_i = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request and hold it until the stall releases.
  task automatic access(input logic rd, input logic wr, input logic [63:0] a,
                        input logic [63:0] d, output int stalls, output logic [63:0] rdat);
    stalls = 0;
    @(negedge clk);
    M_read = rd; M_write = wr; M_addr = a; M_data = d;
    #1;
    while (h_mem !== 1'b0 && stalls < 100) begin
      stalls++;
      @(negedge clk); #1;
    end
    rdat = m_data;
  endtask

  task automatic idle();
    @(negedge clk);
    M_read = 1'b0; M_write = 1'b0; M_addr = '0; M_data = '0;
  endtask

  int          st;
  logic [63:0] rv;

  initial begin
    rst = 1'b1; M_read = 1'b0; M_write = 1'b0; M_addr = '0; M_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_data",  m_data, 64'h0);
    chk("rst_m_error", 64'(m_error), 64'h0);
    chk("rst_stall",   64'(h_mem), 64'h0);
    chk("rst_req",     64'(mif.mem_req_o), 64'h0);
    chk("rst_we",      64'(mif.mem_we_o), 64'h0);
    chk("rst_addr",    mif.mem_addr_o, 64'h0);
    chk("rst_wdata",   mif.mem_wdata_o, 64'h0);
    @(negedge clk); rst = 1'b0;

    // Cold read, ack two cycles after each request.
    ack_lat = 2; rd_log.delete(); wr_log.delete();
    access(1'b1, 1'b0, 64'h100, 64'h0, st, rv);
    chk("cold_stalls", 64'(st), 64'd13);
    chk("cold_data",   rv, mem_rd(64'h100));
    chk("cold_nrd",    64'(rd_log.size()), 64'd4);
    chk("cold_a0",     rd_log[0], 64'h100);
    chk("cold_a1",     rd_log[1], 64'h108);
    chk("cold_a2",     rd_log[2], 64'h110);
    chk("cold_a3",     rd_log[3], 64'h118);
    rd_log.delete();
    access(1'b1, 1'b0, 64'h108, 64'h0, st, rv);
    chk("hit_stalls",  64'(st), 64'd0);
    chk("hit_data",    rv, mem_rd(64'h108));
    chk("hit_noreq",   64'(mif.mem_req_o), 64'h0);
    chk("hit_ntxn",    64'(rd_log.size() + wr_log.size()), 64'd0);

    // Write-through to a cached word, immediate ack.
    ack_lat = 0;
    access(1'b0, 1'b1, 64'h110, 64'hDEAD, st, rv);
    chk("wr_stalls",   64'(st), 64'd1);
    chk("wr_nwr",      64'(wr_log.size()), 64'd1);
    chk("wr_nrd",      64'(rd_log.size()), 64'd0);
    chk("wr_addr",     wr_log[0], 64'h110);
    chk("wr_data",     wr_data_last, 64'hDEAD);
    access(1'b1, 1'b0, 64'h110, 64'h0, st, rv);
    chk("wrhit_stalls", 64'(st), 64'd0);
    chk("wrhit_data",   rv, 64'hDEAD);

    // Store to an uncached line: no allocation, later load fills.
    ack_lat = 1; rd_log.delete(); wr_log.delete();
    access(1'b0, 1'b1, 64'h4000, 64'h1234_5678_9ABC_DEF0, st, rv);
    chk("wrmiss_stalls", 64'(st), 64'd2);
    chk("wrmiss_addr",   wr_log[0], 64'h4000);
    chk("wrmiss_nrd",    64'(rd_log.size()), 64'd0);
    ack_lat = 0;
    access(1'b1, 1'b0, 64'h4000, 64'h0, st, rv);
    chk("ldmiss_stalls", 64'(st), 64'd5);
    chk("ldmiss_nrd",    64'(rd_log.size()), 64'd4);
    chk("ldmiss_data",   rv, 64'h1234_5678_9ABC_DEF0);

    // Misaligned and conflicting requests are errors with no traffic.
    rd_log.delete(); wr_log.delete();
    @(negedge clk); M_read = 1'b1; M_write = 1'b0; M_addr = 64'h103; #1;
    chk("err_rd_flag",  64'(m_error), 64'h1);
    chk("err_rd_stall", 64'(h_mem), 64'h0);
    @(negedge clk); #1;
    chk("err_rd_noreq", 64'(mif.mem_req_o), 64'h0);
    @(negedge clk); M_write = 1'b1; M_addr = 64'h108; #1;
    chk("err_rw_flag",  64'(m_error), 64'h1);
    chk("err_rw_stall", 64'(h_mem), 64'h0);
    @(negedge clk); #1;
    chk("err_rw_noreq", 64'(mif.mem_req_o), 64'h0);
    chk("err_ntxn",     64'(rd_log.size() + wr_log.size()), 64'd0);
    idle(); #1;
    chk("idle_data",    m_data, 64'h0);

    // Conflict eviction on the same index.
    access(1'b1, 1'b0, 64'h300, 64'h0, st, rv);
    chk("evict_stalls", 64'(st), 64'd5);
    chk("evict_data",   rv, mem_rd(64'h300));
    access(1'b1, 1'b0, 64'h100, 64'h0, st, rv);
    chk("reread_stalls", 64'(st), 64'd5);
    chk("reread_data",   rv, mem_rd(64'h100));

    // Reset after two of four fill acks.
    idle();
    M_read = 1'b1; M_addr = 64'h520;
    repeat (3) @(negedge clk);
    rst = 1'b1; M_read = 1'b0; M_addr = '0; #1;
    chk("midrst_req",   64'(mif.mem_req_o), 64'h0);
    chk("midrst_stall", 64'(h_mem), 64'h0);
    @(negedge clk); rst = 1'b0;
    rd_log.delete();
    access(1'b1, 1'b0, 64'h520, 64'h0, st, rv);
    chk("postrst_stalls", 64'(st), 64'd5);
    chk("postrst_nrd",    64'(rd_log.size()), 64'd4);
    chk("postrst_a0",     rd_log[0], 64'h520);
    chk("postrst_data",   rv, mem_rd(64'h520));
    access(1'b1, 1'b0, 64'h100, 64'h0, st, rv);
    chk("postrst_clr",    64'(st), 64'd5);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
